store_buffer: RTL and testbench

Posted-write buffer between the MEM stage and `data_ram`. Stores from the MEM stage are queued in a small FIFO and drained to `data_ram` whenever the RAM port is not needed by a load. Loads get the RAM port combinationally in the same cycle. The block raises a stall request to the pipeline controller when a store finds the buffer full, or when a load hits a word still pending in the buffer.

---
 rtl/store_buffer.sv | 117 +++++++++++
 tb/tb_store_buffer.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO between the MEM stage and data_ram.
// Loads own the RAM port combinationally; queued stores drain whenever the
// port is free. A load that matches a pending word, or a store that finds
// the buffer full with nothing draining, raises stallreq_o.
module store_buffer #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_ce_i,
   input  logic        mem_we_i,
   input  logic [31:0] mem_addr_i,
   input  logic [3:0]  mem_sel_i,
   input  logic [31:0] mem_data_i,
   output logic [31:0] mem_data_o,
   output logic        stallreq_o,
   output logic        buf_empty_o,
   output logic        ram_ce_o,
   output logic        ram_we_o,
   output logic [31:0] ram_addr_o,
   output logic [3:0]  ram_sel_o,
   output logic [31:0] ram_data_o,
   input  logic [31:0] ram_data_i
);

   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   logic [29:0]      ent_addr [DEPTH];
   logic [3:0]       ent_sel  [DEPTH];
   logic [31:0]      ent_data [DEPTH];

   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [PTR_W:0]   count;

   logic             load;
   logic             store;
   logic             hit;
   logic             load_go;
   logic             drain;
   logic             accept;
   logic [DEPTH-1:0] slot_match;

   // A slot is live when its distance from head is below count; compare its word address
   always_comb begin
      logic [PTR_W-1:0] offs;
      offs       = '0;
      slot_match = '0;
      for (int s = 0; s < DEPTH; s++) begin
         offs          = PTR_W'(s) - head;
         slot_match[s] = ({1'b0, offs} < count) && (ent_addr[s] == mem_addr_i[31:2]);
      end
   end

   // Port arbitration: an un-hit load wins, otherwise the head entry drains
   always_comb begin
      load    = mem_ce_i & ~mem_we_i;
      store   = mem_ce_i & mem_we_i;
      hit     = load & (|slot_match);
      load_go = load & ~hit;
      drain   = (count != '0) & ~load_go;
      accept  = store & ((count != FULL_CNT) | drain);
   end

   // Output mux; everything is forced quiet while reset is held
   always_comb begin
      mem_data_o  = '0;
      stallreq_o  = 1'b0;
      ram_ce_o    = 1'b0;
      ram_we_o    = 1'b0;
      ram_addr_o  = '0;
      ram_sel_o   = '0;
      ram_data_o  = '0;
      buf_empty_o = (count == '0);
      if (!rst) begin
         stallreq_o = hit | (store & ~accept);
         if (load_go) begin
            ram_ce_o   = 1'b1;
            ram_addr_o = mem_addr_i;
            mem_data_o = ram_data_i;
         end else if (drain) begin
            ram_ce_o   = 1'b1;
            ram_we_o   = 1'b1;
            ram_addr_o = {ent_addr[head], 2'b00};
            ram_sel_o  = ent_sel[head];
            ram_data_o = ent_data[head];
         end
      end else begin
         buf_empty_o = 1'b1;
      end
   end

   // Pointer and occupancy bookkeeping
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (drain) head <= head + 1'b1;
         if (accept) tail <= tail + 1'b1;
         if (accept && !drain) count <= count + 1'b1;
         else if (drain && !accept) count <= count - 1'b1;
      end
   end

   // Entry storage; contents are meaningless outside the live window so no reset
   always_ff @(posedge clk) begin
      if (accept) begin
         ent_addr[tail] <= mem_addr_i[31:2];
         ent_sel[tail]  <= mem_sel_i;
         ent_data[tail] <= mem_data_i;
      end
   end

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: drives store_buffer against a queue-based reference model
// and a behavioural data_ram.
module tb_store_buffer;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_ce_i, mem_we_i;
   logic [31:0] mem_addr_i, mem_data_i;
   logic [3:0]  mem_sel_i;
   logic [31:0] mem_data_o;
   logic        stallreq_o, buf_empty_o;
   logic        ram_ce_o, ram_we_o;
   logic [31:0] ram_addr_o, ram_data_o, ram_data_i;
   logic [3:0]  ram_sel_o;

   store_buffer #(.DEPTH(DEPTH), .PTR_W(2)) dut (
      .clk(clk), .rst(rst),
      .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
      .mem_sel_i(mem_sel_i), .mem_data_i(mem_data_i), .mem_data_o(mem_data_o),
      .stallreq_o(stallreq_o), .buf_empty_o(buf_empty_o),
      .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
      .ram_sel_o(ram_sel_o), .ram_data_o(ram_data_o), .ram_data_i(ram_data_i)
   );

   always #5 clk = ~clk;

   // behavioural data_ram (4 KB window)
   logic [31:0] env_ram [0:1023];
   int          env_writes = 0;
   logic [31:0] wr_log [$];

   assign ram_data_i = env_ram[ram_addr_o[11:2]];

   always @(posedge clk) begin
      if (ram_ce_o && ram_we_o) begin
         for (int b = 0; b < 4; b++)
            if (ram_sel_o[b]) env_ram[ram_addr_o[11:2]][8*b +: 8] = ram_data_o[8*b +: 8];
         env_writes = env_writes + 1;
         wr_log.push_back(ram_addr_o);
      end
   end

   // reference model: pending stores as a queue, plus the memory image they produce
   typedef struct {
      logic [29:0] a;
      logic [3:0]  s;
      logic [31:0] d;
   } ent_t;
   ent_t        mq [$];
   logic [31:0] ref_mem [0:1023];

   typedef struct packed {
      logic        stall;
      logic [31:0] mdata;
      logic        empty;
      logic        ce;
      logic        we;
      logic [31:0] addr;
      logic [3:0]  sel;
      logic [31:0] data;
   } obs_t;
   obs_t exp_o, got_o;

   int ncheck = 0;
   int nfail  = 0;

   function automatic logic [31:0] init_word(input int i);
      logic [31:0] v;
      v = 32'(i) * 32'h9E37_79B1;
      return v ^ 32'h5A5A_0F0F;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] sel);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
      return r;
   endfunction

   // One MEM-stage cycle: drive, predict, sample, then advance the model at the edge
   task automatic step(input logic ce, input logic we, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] d);
      logic ld, st, hit, ld_go, drn, acc;
      @(negedge clk);
      mem_ce_i = ce; mem_we_i = we; mem_addr_i = a; mem_sel_i = s; mem_data_i = d;
      #1;
      ld  = ce && !we;
      st  = ce && we;
      hit = 1'b0;
      foreach (mq[i]) if (mq[i].a == a[31:2]) hit = 1'b1;
      hit   = hit && ld;
      ld_go = ld && !hit;
      drn   = (mq.size() != 0) && !ld_go;
      acc   = st && ((mq.size() < DEPTH) || drn);
      exp_o       = '0;
      exp_o.empty = (mq.size() == 0);
      exp_o.stall = hit || (st && !acc);
      if (ld_go) begin
         exp_o.ce    = 1'b1;
         exp_o.addr  = a;
         exp_o.mdata = ref_mem[a[11:2]];
      end else if (drn) begin
         exp_o.ce   = 1'b1;
         exp_o.we   = 1'b1;
         exp_o.addr = {mq[0].a, 2'b00};
         exp_o.sel  = mq[0].s;
         exp_o.data = mq[0].d;
      end
      got_o = {stallreq_o, mem_data_o, buf_empty_o, ram_ce_o, ram_we_o,
               ram_addr_o, ram_sel_o, ram_data_o};
      if (ld_go) begin
         got_o.sel  = '0;
         got_o.data = '0;
      end
      @(posedge clk);
      if (drn) begin
         ref_mem[mq[0].a[9:0]] = merge(ref_mem[mq[0].a[9:0]], mq[0].d, mq[0].s);
         void'(mq.pop_front());
      end
      if (acc) mq.push_back('{a[31:2], s, d});
   endtask

   task automatic test_reset();
      rst = 1'b1;
      mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h40; mem_sel_i = 4'hF; mem_data_i = '0;
      #12;
      exp_o = '0; exp_o.empty = 1'b1;
      got_o = {stallreq_o, mem_data_o, buf_empty_o, ram_ce_o, ram_we_o,
               ram_addr_o, ram_sel_o, ram_data_o};
      ncheck++;
      if (got_o !== exp_o) begin
         nfail++; $display("FAIL reset_outputs got %h exp %h", got_o, exp_o);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_store_drain();
      step(1, 1, 32'h100, 4'hF, 32'h1122_3344);
      ncheck++; if (got_o !== exp_o) begin nfail++; $display("FAIL sd_store got %h exp %h", got_o, exp_o); end
      step(0, 0, 32'h0, 4'h0, 32'h0);
      ncheck++; if (got_o !== exp_o) begin nfail++; $display("FAIL sd_drain got %h exp %h", got_o, exp_o); end
      ncheck++;
      if (!(got_o.we === 1'b1 && got_o.addr === 32'h100 && got_o.data === 32'h1122_3344)) begin
         nfail++; $display("FAIL sd_drain_port got we=%b addr=%h data=%h exp we=1 addr=100 data=11223344",
                           got_o.we, got_o.addr, got_o.data);
      end
      step(0, 0, 32'h0, 4'h0, 32'h0);
      ncheck++;
      if (got_o.empty !== 1'b1) begin nfail++; $display("FAIL sd_empty got %b exp 1", got_o.empty); end
      step(1, 0, 32'h100, 4'hF, 32'h0);
      ncheck++;
      if (got_o.mdata !== 32'h1122_3344) begin
         nfail++; $display("FAIL sd_load got %h exp 11223344", got_o.mdata);
      end
   endtask

   task automatic test_load_hit();
      logic [31:0] d;
      d = $urandom;
      step(1, 1, 32'h200, 4'hF, d);
      ncheck++; if (got_o !== exp_o) begin nfail++; $display("FAIL lh_store got %h exp %h", got_o, exp_o); end
      step(1, 0, 32'h200, 4'hF, 32'h0);
      ncheck++; if (got_o !== exp_o) begin nfail++; $display("FAIL lh_hit got %h exp %h", got_o, exp_o); end
      ncheck++;
      if (got_o.stall !== 1'b1 || got_o.mdata !== 32'h0) begin
         nfail++; $display("FAIL lh_stall got stall=%b data=%h exp stall=1 data=0", got_o.stall, got_o.mdata);
      end
      step(1, 0, 32'h200, 4'hF, 32'h0);
      ncheck++;
      if (got_o.stall !== 1'b0 || got_o.mdata !== d) begin
         nfail++; $display("FAIL lh_result got stall=%b data=%h exp stall=0 data=%h", got_o.stall, got_o.mdata, d);
      end
   endtask

   task automatic test_byte_merge();
      env_ram[32'h300 >> 2] = 32'h0102_0304;
      ref_mem[32'h300 >> 2] = 32'h0102_0304;
      step(1, 1, 32'h300, 4'b1000, 32'hAB00_0000);
      ncheck++; if (got_o !== exp_o) begin nfail++; $display("FAIL bm_store got %h exp %h", got_o, exp_o); end
      step(0, 0, 32'h0, 4'h0, 32'h0);
      ncheck++; if (got_o !== exp_o) begin nfail++; $display("FAIL bm_drain got %h exp %h", got_o, exp_o); end
      step(1, 0, 32'h300, 4'hF, 32'h0);
      ncheck++;
      if (got_o.mdata !== 32'hAB02_0304) begin
         nfail++; $display("FAIL bm_load got %h exp ab020304", got_o.mdata);
      end
   endtask

   task automatic test_fifo_order();
      int          base;
      logic [31:0] want [4];
      want = '{32'h0, 32'h4, 32'h8, 32'hC};
      base = wr_log.size();
      for (int i = 0; i < 4; i++) begin
         step(1, 1, want[i], 4'hF, $urandom);
         ncheck++; if (got_o !== exp_o) begin nfail++; $display("FAIL fo_store%0d got %h exp %h", i, got_o, exp_o); end
         step(1, 0, 32'h40, 4'hF, 32'h0);
         ncheck++; if (got_o !== exp_o) begin nfail++; $display("FAIL fo_load%0d got %h exp %h", i, got_o, exp_o); end
      end
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 32'h0, 4'h0, 32'h0);
         ncheck++; if (got_o !== exp_o) begin nfail++; $display("FAIL fo_idle%0d got %h exp %h", i, got_o, exp_o); end
      end
      ncheck++;
      if (wr_log.size() - base != 4) begin
         nfail++; $display("FAIL fo_count got %0d writes exp 4", wr_log.size() - base);
      end else begin
         for (int i = 0; i < 4; i++) begin
            ncheck++;
            if (wr_log[base+i] !== want[i]) begin
               nfail++; $display("FAIL fo_order%0d got %h exp %h", i, wr_log[base+i], want[i]);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      step(1, 1, 32'h500, 4'hF, 32'hAAAA_AAAA);
      ncheck++; if (got_o !== exp_o) begin nfail++; $display("FAIL bb_st1 got %h exp %h", got_o, exp_o); end
      step(1, 1, 32'h500, 4'hF, 32'h5555_5555);
      ncheck++; if (got_o !== exp_o) begin nfail++; $display("FAIL bb_st2 got %h exp %h", got_o, exp_o); end
      step(0, 0, 32'h0, 4'h0, 32'h0);
      step(0, 0, 32'h0, 4'h0, 32'h0);
      step(1, 0, 32'h500, 4'hF, 32'h0);
      ncheck++;
      if (got_o.mdata !== 32'h5555_5555) begin
         nfail++; $display("FAIL bb_final got %h exp 55555555", got_o.mdata);
      end
   endtask

   task automatic test_reset_mid_drain();
      int n_before;
      step(1, 1, 32'h600, 4'hF, 32'hDEAD_BEEF);
      @(negedge clk);
      mem_ce_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = '0; mem_sel_i = '0; mem_data_i = '0;
      #1;
      ncheck++;
      if (ram_we_o !== 1'b1) begin nfail++; $display("FAIL rm_drain_active got we=%b exp 1", ram_we_o); end
      n_before = env_writes;
      #1 rst = 1'b1;
      #1;
      exp_o = '0; exp_o.empty = 1'b1;
      got_o = {stallreq_o, mem_data_o, buf_empty_o, ram_ce_o, ram_we_o,
               ram_addr_o, ram_sel_o, ram_data_o};
      ncheck++;
      if (got_o !== exp_o) begin nfail++; $display("FAIL rm_outputs got %h exp %h", got_o, exp_o); end
      mem_ce_i = 1'b1; mem_addr_i = 32'h40;
      #1;
      got_o = {stallreq_o, mem_data_o, buf_empty_o, ram_ce_o, ram_we_o,
               ram_addr_o, ram_sel_o, ram_data_o};
      ncheck++;
      if (got_o !== exp_o) begin nfail++; $display("FAIL rm_outputs_load got %h exp %h", got_o, exp_o); end
      mq.delete();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      step(0, 0, 32'h0, 4'h0, 32'h0);
      ncheck++; if (got_o !== exp_o) begin nfail++; $display("FAIL rm_idle got %h exp %h", got_o, exp_o); end
      step(1, 0, 32'h600, 4'hF, 32'h0);
      ncheck++; if (got_o !== exp_o) begin nfail++; $display("FAIL rm_load got %h exp %h", got_o, exp_o); end
      ncheck++;
      if (env_writes != n_before) begin
         nfail++; $display("FAIL rm_writes got %0d exp %0d", env_writes, n_before);
      end
   endtask

   task automatic test_random();
      logic        ce, we;
      logic [31:0] a, d;
      logic [3:0]  s;
      ce = 0; we = 0; a = 0; d = 0; s = 0;
      for (int i = 0; i < 400; i++) begin
         if (i == 0 || !exp_o.stall) begin
            ce = ($urandom_range(0, 3) != 0);
            we = $urandom_range(0, 1);
            a  = 32'h800 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
            s  = 4'($urandom_range(1, 15));
            d  = $urandom;
         end
         step(ce, we, a, s, d);
         ncheck++;
         if (got_o !== exp_o) begin
            nfail++; $display("FAIL rnd_cycle%0d got %h exp %h", i, got_o, exp_o);
         end
      end
      for (int i = 0; i < 2; i++) step(0, 0, 32'h0, 4'h0, 32'h0);
      for (int w = 0; w < 8; w++) begin
         step(1, 0, 32'h800 + 32'(4 * w), 4'hF, 32'h0);
         ncheck++;
         if (got_o !== exp_o) begin nfail++; $display("FAIL rnd_final%0d got %h exp %h", w, got_o, exp_o); end
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) begin
         env_ram[i] = init_word(i);
         ref_mem[i] = init_word(i);
      end
      exp_o = '0;
      got_o = '0;
      test_reset();
      test_store_drain();
      test_load_hit();
      test_byte_merge();
      test_fifo_order();
      test_back_to_back();
      test_reset_mid_drain();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", ncheck, nfail);
      $finish;
   end

endmodule
